// File: rtl/bcd_scan_display.sv
// Binary-to-BCD converter (iterative double-dabble, 18-cycle period) driving a
// time-multiplexed 4-digit common-anode seven-segment display.
module bcd_scan_display #(
  parameter int unsigned PRESCALE_W = 16,
  parameter bit          BLANK_LZ   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  output logic [15:0] bcd_out,
  output logic        overflow,
  output logic        bcd_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);
  localparam logic [6:0]            SEG_DASH  = 7'b0111111;
  localparam logic [6:0]            SEG_OFF   = 7'b1111111;

  state_t state, state_nxt;

  logic [15:0] bin_q;
  logic [15:0] acc_q;
  logic [3:0]  bit_cnt;
  logic        ovf_q;

  logic [15:0] acc_adj;
  logic [15:0] acc_shift;
  logic [15:0] bin_shift;
  logic        last_shift;

  logic [PRESCALE_W-1:0] presc_q;
  logic [1:0]            digit_sel;
  logic [3:0]            digit;
  logic                  lz_zero;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Per-nibble add-3 with no inter-nibble carry, then one combined left shift.
  always_comb begin
    logic [3:0] nib;
    acc_adj = acc_q;
    for (int unsigned i = 0; i < 4; i++) begin
      nib = acc_q[4*i +: 4];
      acc_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    acc_shift  = {acc_adj[14:0], bin_q[15]};
    bin_shift  = {bin_q[14:0], 1'b0};
    last_shift = (bit_cnt == 4'd15);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bcd_valid = 1'b0;
    case (state)
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (last_shift) state_nxt = S_DONE;
      S_DONE: begin
        bcd_valid = 1'b1;
        state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Commit happens on the edge entering S_DONE so bcd_out/overflow are already
  // updated during the cycle in which bcd_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      acc_q    <= '0;
      bit_cnt  <= '0;
      ovf_q    <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          bin_q   <= value_in;
          acc_q   <= '0;
          bit_cnt <= '0;
          ovf_q   <= (value_in > 16'd9999);
        end
        S_SHIFT: begin
          acc_q   <= acc_shift;
          bin_q   <= bin_shift;
          bit_cnt <= bit_cnt + 4'd1;
          if (last_shift) begin
            bcd_out  <= acc_shift;
            overflow <= ovf_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      digit_sel <= '0;
    end else begin
      presc_q <= presc_q + PRESC_ONE;
      if (presc_q == '1) begin
        digit_sel <= digit_sel + 2'd1;
      end
    end
  end

  always_comb begin
    digit   = bcd_out[{digit_sel, 2'b00} +: 4];
    lz_zero = 1'b0;
    case (digit_sel)
      2'd3:    lz_zero = (bcd_out[15:12] == 4'd0);
      2'd2:    lz_zero = (bcd_out[15:8] == 8'd0);
      2'd1:    lz_zero = (bcd_out[15:4] == 12'd0);
      default: lz_zero = 1'b0;
    endcase

    an = ~(4'b0001 << digit_sel);
    if (overflow) begin
      seg = SEG_DASH;
    end else if (BLANK_LZ && lz_zero) begin
      seg = SEG_OFF;
    end else begin
      seg = seg_decode(digit);
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized bench for bcd_scan_display: two instances (with and without
// leading-zero blanking) checked every cycle against an arithmetic model.
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;

  logic [15:0] bcd_out,   bcd_out_lz;
  logic        overflow,  overflow_lz;
  logic        bcd_valid, bcd_valid_lz;
  logic [3:0]  an,        an_lz;
  logic [6:0]  seg,       seg_lz;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int ncyc    = 0;
  int samp    = 0;
  int mdl_val = 0;
  bit mdl_ovf = 1'b0;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  bcd_scan_display #(.PRESCALE_W(2), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .rst(rst), .value_in(value_in),
    .bcd_out(bcd_out), .overflow(overflow), .bcd_valid(bcd_valid),
    .an(an), .seg(seg)
  );

  bcd_scan_display #(.PRESCALE_W(2), .BLANK_LZ(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .value_in(value_in),
    .bcd_out(bcd_out_lz), .overflow(overflow_lz), .bcd_valid(bcd_valid_lz),
    .an(an_lz), .seg(seg_lz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input bit ovf, input int sel, input bit blank);
    int p = 1;
    for (int i = 0; i < sel; i++) p = p * 10;
    if (ovf) return 7'b0111111;
    if (blank && sel > 0 && v < p) return 7'b1111111;
    return SEG_TAB[(v / p) % 10];
  endfunction

  // Model timeline: LOAD at phase 0 after reset, result visible at phase 17.
  always @(posedge clk) begin
    if (rst) begin
      ncyc    <= 0;
      mdl_val <= 0;
      mdl_ovf <= 1'b0;
    end else begin
      ncyc <= ncyc + 1;
      if (ncyc % 18 == 0) samp <= int'(value_in);
      if (ncyc % 18 == 16) begin
        mdl_val <= samp % 10000;
        mdl_ovf <= (samp > 9999);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int sel;
      sel = (ncyc / 4) % 4;
      check("bcd_out",   32'(bcd_out),   32'(to_bcd(mdl_val)));
      check("overflow",  32'(overflow),  32'(mdl_ovf));
      check("bcd_valid", 32'(bcd_valid), 32'(ncyc % 18 == 17));
      check("an",        32'(an),        32'(~(4'b0001 << sel) & 4'hf));
      check("seg",       32'(seg),       32'(exp_seg(mdl_val, mdl_ovf, sel, 1'b0)));
      check("an_lz",     32'(an_lz),     32'(~(4'b0001 << sel) & 4'hf));
      check("seg_lz",    32'(seg_lz),    32'(exp_seg(mdl_val, mdl_ovf, sel, 1'b1)));
      check("bcd_out_lz", 32'(bcd_out_lz), 32'(to_bcd(mdl_val)));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [15:0] v, input int n);
    value_in = v;
    step(n);
  endtask

  task automatic wait_phase(input int ph);
    for (int k = 0; k < 40 && (ncyc % 18) != ph; k++) step(1);
    check("wait_phase", 32'(ncyc % 18), 32'(ph));
  endtask

  initial begin
    rst      = 1'b1;
    value_in = '0;
    step(1);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;

    hold(16'd1234, 40);
    hold(16'd9999, 40);
    hold(16'd10000, 40);
    hold(16'd65535, 40);
    hold(16'd7, 40);
    hold(16'd0, 40);

    // Value changes while a conversion is in flight.
    wait_phase(0);
    value_in = 16'd42;
    step(3);
    value_in = 16'd77;
    step(40);

    // Reset in the middle of a conversion.
    hold(16'd1234, 40);
    wait_phase(2);
    value_in = 16'd5678;
    wait_phase(8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(40);

    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       value_in = 16'($urandom_range(0, 9));
          1:       value_in = 16'($urandom_range(0, 9999));
          2:       value_in = 16'($urandom_range(10000, 65535));
          default: value_in = 16'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    step(40);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
